irq_trap_ctrl: RTL

IRQ_TRAP_CTRL -- requirements
Module: irq_trap_ctrl

---
 rtl/irq_trap_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/irq_trap_ctrl.sv
// Interrupt/trap controller: rising-edge pending latch, fixed-priority select, three-state
// trap handshake. Define IRQ_VECTORED_EN for per-cause vector offsets (TVEC_BASE + 4*cause).
module irq_trap_ctrl #(
    parameter int unsigned     N_IRQ     = 8,
    parameter int unsigned     XLEN      = 64,
    parameter logic [XLEN-1:0] TVEC_BASE = 64'h0000_0000_0000_0100
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_IRQ-1:0]         irq_in,
    input  logic                     mie_we,
    input  logic [N_IRQ-1:0]         mie_wdata,
    input  logic                     gie_we,
    input  logic                     gie_wdata,
    input  logic [XLEN-1:0]          pc_in,
    input  logic                     trap_ack,
    input  logic                     mret,
    output logic                     trap,
    output logic [$clog2(N_IRQ)-1:0] trap_cause,
    output logic [XLEN-1:0]          trap_vec,
    output logic [XLEN-1:0]          epc,
    output logic                     irq_out,
    output logic                     in_handler,
    output logic [N_IRQ-1:0]         pending,
    output logic [N_IRQ-1:0]         mie,
    output logic                     gie
);

    localparam int unsigned CW = $clog2(N_IRQ);

    typedef enum logic [1:0] {StIdle, StTrapReq, StInHandler} state_e;

    state_e           state_q, state_d;
    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] mie_q, mie_d;
    logic             gie_q, gie_d;
    logic [CW-1:0]    cause_q, cause_d;
    logic [XLEN-1:0]  epc_q, epc_d;

    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] masked;
    logic [N_IRQ-1:0] claim;
    logic [CW-1:0]    sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            irq_q     <= '0;
            pending_q <= '0;
            mie_q     <= '0;
            gie_q     <= 1'b0;
            cause_q   <= '0;
            epc_q     <= '0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_in;
            pending_q <= pending_d;
            mie_q     <= mie_d;
            gie_q     <= gie_d;
            cause_q   <= cause_d;
            epc_q     <= epc_d;
        end
    end

    // Lowest set index wins: scan downward so the last assignment is the lowest.
    always_comb begin
        sel = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (masked[i]) sel = CW'(i);
        end
    end

    always_comb begin
        rise    = irq_in & ~irq_q;
        masked  = pending_q & mie_q;
        claim   = '0;
        state_d = state_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        mie_d   = mie_we ? mie_wdata : mie_q;
        gie_d   = gie_we ? gie_wdata : gie_q;

        unique case (state_q)
            StIdle: begin
                if (gie_q && |masked) begin
                    state_d = StTrapReq;
                    cause_d = sel;
                    gie_d   = 1'b0;
                end
            end
            StTrapReq: begin
                if (trap_ack) begin
                    state_d = StInHandler;
                    epc_d   = pc_in;
                    claim   = {{(N_IRQ-1){1'b0}}, 1'b1} << cause_q;
                end
            end
            StInHandler: begin
                if (mret) begin
                    state_d = StIdle;
                    gie_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A fresh edge on the claimed line survives the claim.
        pending_d = (pending_q & ~claim) | rise;
    end

`ifdef IRQ_VECTORED_EN
    assign trap_vec = TVEC_BASE + (XLEN'(cause_q) << 2);
`else
    assign trap_vec = TVEC_BASE;
`endif

    assign trap       = (state_q == StTrapReq);
    assign in_handler = (state_q == StInHandler);
    assign trap_cause = cause_q;
    assign epc        = epc_q;
    assign irq_out    = |masked;
    assign pending    = pending_q;
    assign mie        = mie_q;
    assign gie        = gie_q;

endmodule
